// File: rtl/ixc_osf_pkg.sv
// ixc_osf_pkg
// Shared definitions for the OSF mailbox event collector.
//   NUM_EV_DEF : default event vector width (matches the 20-bit OSF mailbox vector)
//   OVF_W_DEF  : default overflow counter width
//   state_t    : collector FSM states
package ixc_osf_pkg;

  localparam int NUM_EV_DEF = 20;
  localparam int OVF_W_DEF  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/ixc_osf_sat_cnt.sv
// ixc_osf_sat_cnt
// Saturating up-counter used for the collision (overflow) count.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears value
//   inc   : add one (holds at all-ones)
//   clr   : clear; when asserted together with inc the result is 1
//   value : current count
module ixc_osf_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (clr) begin
      // A collision in the clearing cycle is still counted.
      value_reg <= inc ? W'(1) : '0;
    end else if (inc && (value_reg != {W{1'b1}})) begin
      value_reg <= value_reg + W'(1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/ixc_osf_evt_collect.sv
// ixc_osf_evt_collect
// Collects masked per-bit event strobes into a pending vector and offers
// them to the OSF mailbox as batches with a valid/ack handshake.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   ev_in    : per-bit event strobes
//   ev_en    : per-bit event enables
//   clr_ovf  : clears overflow counter and flag
//   mb_ack   : mailbox accepts mb_vec when high with mb_valid
//   mb_vec   : batch offered to the mailbox
//   mb_valid : mb_vec is valid
//   pending  : events captured but not yet offered
//   ovf_cnt  : saturating count of collision cycles
//   ovf_flag : sticky collision flag
module ixc_osf_evt_collect
  import ixc_osf_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_DEF,
  parameter int OVF_W  = OVF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EV-1:0] ev_in,
  input  logic [NUM_EV-1:0] ev_en,
  input  logic              clr_ovf,
  input  logic              mb_ack,
  output logic [NUM_EV-1:0] mb_vec,
  output logic              mb_valid,
  output logic [NUM_EV-1:0] pending,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              ovf_flag
);

  state_t            state_reg;
  logic [NUM_EV-1:0] pending_reg;
  logic [NUM_EV-1:0] mb_vec_reg;
  logic              mb_valid_reg;
  logic              ovf_flag_reg;
  logic [NUM_EV-1:0] ev_m;
  logic              collision;

  assign ev_m = ev_in & ev_en;

  // In IDLE a non-empty pending vector is always transferred on that edge,
  // and an empty one cannot overlap ev_m, so collisions only happen in OFFER.
  assign collision = (state_reg == OFFER) && ((ev_m & pending_reg) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      mb_vec_reg   <= '0;
      mb_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg == '0) begin
            pending_reg <= pending_reg | ev_m;
          end else begin
            mb_vec_reg   <= pending_reg;
            pending_reg  <= ev_m;
            mb_valid_reg <= 1'b1;
            state_reg    <= OFFER;
          end
        end
        OFFER: begin
          pending_reg <= pending_reg | ev_m;
          if (mb_ack) begin
            mb_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag_reg <= 1'b0;
    end else if (clr_ovf) begin
      ovf_flag_reg <= collision;
    end else if (collision) begin
      ovf_flag_reg <= 1'b1;
    end
  end

  ixc_osf_sat_cnt #(
    .W(OVF_W)
  ) u_ovf_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (collision),
    .clr  (clr_ovf),
    .value(ovf_cnt)
  );

  assign mb_vec   = mb_vec_reg;
  assign mb_valid = mb_valid_reg;
  assign pending  = pending_reg;
  assign ovf_flag = ovf_flag_reg;

endmodule

// File: tb/tb_ixc_osf_evt_collect.sv
module tb_ixc_osf_evt_collect;

  localparam int NE = 20;
  localparam int OW = 8;
  localparam int OVF_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] ev_in;
  logic [NE-1:0] ev_en;
  logic          clr_ovf;
  logic          mb_ack;
  logic [NE-1:0] mb_vec;
  logic          mb_valid;
  logic [NE-1:0] pending;
  logic [OW-1:0] ovf_cnt;
  logic          ovf_flag;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: "offering" means a batch sits at the mailbox.
  bit            m_offering;
  logic [NE-1:0] m_batch;
  logic [NE-1:0] m_pend;
  int            m_cnt;
  bit            m_flag;

  always #5 clk = ~clk;

  ixc_osf_evt_collect #(.NUM_EV(NE), .OVF_W(OW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_in   (ev_in),
    .ev_en   (ev_en),
    .clr_ovf (clr_ovf),
    .mb_ack  (mb_ack),
    .mb_vec  (mb_vec),
    .mb_valid(mb_valid),
    .pending (pending),
    .ovf_cnt (ovf_cnt),
    .ovf_flag(ovf_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model by the rules, then compare everything.
  task automatic cyc();
    logic [NE-1:0] evm;
    bit            hit;
    @(posedge clk);
    evm = ev_in & ev_en;
    hit = 1'b0;
    if (rst) begin
      m_offering = 0; m_batch = '0; m_pend = '0; m_cnt = 0; m_flag = 0;
    end else begin
      if (m_offering) begin
        hit    = (evm & m_pend) != '0;
        m_pend = m_pend | evm;
        if (mb_ack) m_offering = 0;
      end else if (m_pend != '0) begin
        m_batch    = m_pend;
        m_pend     = evm;
        m_offering = 1;
      end else begin
        m_pend = evm;
      end
      if (clr_ovf) begin
        m_cnt  = hit ? 1 : 0;
        m_flag = hit;
      end else if (hit) begin
        m_cnt  = (m_cnt + 1 > OVF_MAX) ? OVF_MAX : m_cnt + 1;
        m_flag = 1;
      end
    end
    #1;
    chk("mb_valid", 32'(mb_valid), 32'(m_offering));
    if (m_offering || rst) chk("mb_vec", 32'(mb_vec), 32'(m_batch));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    chk("ovf_flag", 32'(ovf_flag), 32'(m_flag));
  endtask

  task automatic drain();
    ev_in = '0; mb_ack = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; ev_in = '0; ev_en = '1; clr_ovf = 1'b0; mb_ack = 1'b0;
    m_offering = 0; m_batch = '0; m_pend = '0; m_cnt = 0; m_flag = 0;
    cyc(); cyc();
    chk("reset_valid", 32'(mb_valid), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ovf", 32'(ovf_cnt), 32'd0);
    rst = 1'b0;

    // Latency: event at edge 0, offered after edge 1, accepted at edge 2.
    mb_ack = 1'b1; ev_in = 20'h00001; cyc();
    ev_in = '0; cyc();
    chk("lat_valid", 32'(mb_valid), 32'd1);
    chk("lat_vec", 32'(mb_vec), 32'h00001);
    cyc();
    chk("lat_done_valid", 32'(mb_valid), 32'd0);
    chk("lat_done_pend", 32'(pending), 32'd0);

    // Back-pressure: offer 0x3 held while a new event accumulates.
    mb_ack = 1'b0; ev_in = 20'h00003; cyc();
    ev_in = '0; cyc();                       // offer edge
    for (int i = 1; i <= 9; i++) begin
      ev_in = (i == 3) ? 20'h80000 : '0;
      cyc();
    end
    chk("bp_vec", 32'(mb_vec), 32'h00003);
    chk("bp_pend", 32'(pending), 32'h80000);
    mb_ack = 1'b1; ev_in = '0; cyc();        // accepted
    cyc();                                   // next offer
    chk("bp_next_vec", 32'(mb_vec), 32'h80000);
    chk("bp_next_valid", 32'(mb_valid), 32'd1);
    cyc();

    // Collisions and saturation.
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    mb_ack = 1'b0; ev_in = 20'h00001; cyc();
    ev_in = '0; cyc();
    ev_in = 20'h00010; cyc();
    ev_in = 20'h00010; cyc();
    ev_in = 20'h00030; cyc();
    chk("coll_cnt", 32'(ovf_cnt), 32'd2);
    chk("coll_flag", 32'(ovf_flag), 32'd1);
    ev_in = 20'h00010;
    for (int i = 0; i < 300; i++) cyc();
    chk("sat_cnt", 32'(ovf_cnt), 32'd255);
    drain();

    // Clear and collision in the same cycle.
    mb_ack = 1'b0; ev_in = 20'h00001; cyc();
    ev_in = '0; cyc();
    ev_in = 20'h00002; cyc();
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("clr_coll_cnt", 32'(ovf_cnt), 32'd1);
    chk("clr_coll_flag", 32'(ovf_flag), 32'd1);
    drain();

    // Masking.
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    mb_ack = 1'b0; ev_en = 20'h0000F; ev_in = 20'hFFFFF; cyc();
    ev_in = '0; cyc();
    chk("mask_vec", 32'(mb_vec), 32'h0000F);
    ev_en = '1; ev_in = 20'hFFFF0; cyc();
    ev_en = 20'h0000F; ev_in = 20'hFFFFF; cyc();
    chk("mask_nocoll", 32'(ovf_cnt), 32'd0);
    chk("mask_keep_pend", 32'(pending), 32'hFFFFF);
    ev_en = '1; drain();

    // Reset during OFFER.
    mb_ack = 1'b0; ev_in = 20'h00001; cyc();
    ev_in = '0; cyc();
    ev_in = 20'h00100; cyc();
    cyc();                                   // collision to make ovf nonzero
    ev_in = '0; rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_valid", 32'(mb_valid), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    mb_ack = 1'b0; cyc(); cyc();
    chk("rst_no_offer", 32'(mb_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ev_en   = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '1;
      ev_in   = NE'($urandom & $urandom & $urandom);
      mb_ack  = $urandom_range(0, 3) != 0;
      clr_ovf = $urandom_range(0, 63) == 0;
      rst     = $urandom_range(0, 255) == 0;
      cyc();
    end
    rst = 1'b0; clr_ovf = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ixc_osf_evt_collect.md
IXC_OSF_EVT_COLLECT -- requirements
Module: ixc_osf_evt_collect

Interface
REQ-001 SHALL have parameter NUM_EV, default 20, the event vector width, matching the 20-bit OSF mailbox event vector.
REQ-002 SHALL have parameter OVF_W, default 8, the overflow counter width.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port ev_in  input  NUM_EV  per-bit event strobes; each high bit in a cycle is one event.
REQ-007 SHALL have port ev_en  input  NUM_EV  per-bit enable; masked bits are ignored.
REQ-008 SHALL have port clr_ovf  input  1  clears the overflow counter and overflow flag.
REQ-009 SHALL have port mb_ack  input  1  mailbox accepts mb_vec when high together with mb_valid.
REQ-010 SHALL have port mb_vec  output  NUM_EV  event batch offered to the mailbox.
REQ-011 SHALL have port mb_valid  output  1  mb_vec is valid.
REQ-012 SHALL have port pending  output  NUM_EV  events captured but not yet offered.
REQ-013 SHALL have port ovf_cnt  output  OVF_W  saturating count of collision cycles.
REQ-014 SHALL have port ovf_flag  output  1  sticky; set on any collision.

Function
REQ-015 SHALL compute ev_m = ev_in & ev_en each cycle.
REQ-016 SHALL implement the states IDLE and OFFER.
REQ-017 SHALL, in IDLE with pending == 0, OR ev_m into pending each cycle.
REQ-018 SHALL, in IDLE with pending != 0, on that edge: mb_vec <= pending; pending <= ev_m; mb_valid <= 1; go to OFFER.
REQ-019 SHALL, in OFFER, hold mb_vec and mb_valid stable until mb_valid & mb_ack.
REQ-020 SHALL, in OFFER, OR ev_m into pending each cycle.
REQ-021 SHALL, on acceptance, set mb_valid <= 0 and return to IDLE; at least one idle cycle separates offers.
REQ-022 SHALL give a latency from ev_in high (edge k) to mb_valid visible after edge k+1 when in IDLE with pending empty: 2 cycles.
REQ-023 SHALL flag a collision in any cycle where (ev_m & pending) != 0, except in the transfer cycle of REQ-018.
REQ-024 SHALL, per collision cycle, increment ovf_cnt by exactly 1 (regardless of how many bits collide), saturating at 2^OVF_W-1, and set ovf_flag.
REQ-025 SHALL, when clr_ovf and a collision occur in the same cycle, set ovf_cnt <= 1 and ovf_flag <= 1; otherwise clr_ovf sets both to 0.
REQ-026 SHALL apply ev_en changes only to events in the same cycle; already-pending bits are not removed.
REQ-027 SHALL treat mb_ack outside OFFER as ignored.

Reset
REQ-028 SHALL, with rst high at an edge, set the state to IDLE and mb_vec, mb_valid, pending, ovf_cnt and ovf_flag to 0, overriding all other inputs.
REQ-029 SHALL, on reset in OFFER, drop the offered batch; no ack is required afterwards.

Structure
REQ-030 SHALL place NUM_EV, OVF_W defaults and the state enum (IDLE, OFFER) in shared package ixc_osf_pkg.
REQ-031 SHALL implement the saturating overflow counter as sub-module ixc_osf_sat_cnt (inc, clr, value; clr+inc -> 1).

Verification
REQ-032 SHALL cover: ev_in=0x00001 at cycle 0, ev_en=all ones, mb_ack tied 1 -> mb_valid=1, mb_vec=0x00001 at cycle 2, mb_valid=0 at cycle 3, pending=0.
REQ-033 SHALL cover: mb_ack=0 for 10 cycles after offer of 0x00003, ev_in=0x80000 at offer+3 -> mb_vec stays 0x00003, pending=0x80000, and after the ack the next offer is 0x80000.
REQ-034 SHALL cover: bit 4 pending, ev_in=0x00010 and 0x00030 on two consecutive cycles -> ovf_cnt=2, ovf_flag=1; 300 collision cycles -> ovf_cnt=255.
REQ-035 SHALL cover: ev_en=0x0000F, ev_in=0xFFFFF -> mb_vec=0x0000F, no collision counted for the masked bits.
REQ-036 SHALL cover: rst high during OFFER with pending=0x00100 -> next cycle mb_valid=0, pending=0, ovf_cnt=0, state IDLE.
REQ-037 SHALL cover: clr_ovf and a collision in the same cycle -> ovf_cnt=1, ovf_flag=1.
